hex_dump_arbiter: RTL
=====================

# hex_dump_arbiter

Two-port round-robin arbiter and sequencer that shares one byte-stream sink (UART transmitter or USB FIFO) between two word producers. Each accepted word is serialized as an ASCII line: tag character, `:`, lowercase hex digits MSB-first, then a terminator. It sits between capture logic (e.g. address/opcode monitors) and the host-bound byte channel, so that at most one message is on the wire at a time and messages never interleave.

## Interface
- `DIGITS`, 8: hex digits per word; word width W = 4*DIGITS; legal range 1..16.
- `TAG_A`, "A": 8-bit ASCII tag emitted for port A messages.
- `TAG_B`, "B": 8-bit ASCII tag emitted for port B messages.

- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `a_data`  in  W  port A word.
- `a_valid`  in  1  port A word available.
- `a_ready`  out  1  port A word accepted this cycle (combinational).
- `b_data`  in  W  port B word.
- `b_valid`  in  1  port B word available.
- `b_ready`  out  1  port B word accepted this cycle (combinational).
- `out_byte`  out  8  ASCII byte to sink (registered).
- `out_valid`  out  1  `out_byte` valid (registered).
- `out_ready`  in  1  sink accepts byte.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, TAG, COLON, DIGIT, TERM.
- IDLE: grant computed from valids and `last` (last port served). One valid → that port. Both valid → port != `last`. Exactly one of `a_ready`/`b_ready` high, only in IDLE, only for the granted valid port; both low otherwise.
- On acceptance: latch data into shift register, latch tag, `last` ← granted port, digit counter ← DIGITS-1, go TAG with `out_byte`=tag, `out_valid`=1.
- A byte transfers when `out_valid && out_ready`. On transfer advance: TAG → COLON (`:`=0x3A) → DIGIT (DIGITS bytes, top nibble → lowercase "0"-"9","a"-"f", shift register left by 4) → TERM → IDLE.
- While `out_valid && !out_ready`: `out_byte` and state held stable; no input accepted.
- Leaving TERM on last-byte transfer: `out_valid` ← 0, state IDLE. New grant is possible the next cycle.
- Input data changes after acceptance have no effect on the message in flight.
- Reset (any time, including mid-message): state IDLE, `out_valid`=0, `out_byte`=0x00, `busy`=0, shift register 0, `last`=B (so A wins the first tie). Partial message is abandoned, not completed.

## Timing
- Accept at edge N → tag on `out_byte` with `out_valid` at N+1.
- `out_ready` held 1: one byte per cycle; message occupies 1 + (2 + DIGITS + T) cycles, T = terminator length; back-to-back messages separated by exactly one IDLE cycle (accept cycle, `out_valid`=0).
- `a_ready`/`b_ready` depend combinationally on `a_valid`/`b_valid`, state and `last` only; never on `out_ready`.
- Digit counter width $clog2(DIGITS) (min 1); counter reaching 0 on transfer exits DIGIT.

## Configuration
- `HEX_DUMP_EOL_EN` defined: TERM emits two bytes, 0x0D then 0x0A (T=2); a one-bit sub-index selects CR/LF.
- Not defined: TERM emits single 0x20 space (T=1); sub-index logic absent.

## Test plan
- Reset then `a_valid`=1, `a_data`=0xdeadbeef, `out_ready`=1 → `a_ready` high one cycle; bytes "A",":","d","e","a","d","b","e","e","f", then 0x0D,0x0A (EOL_EN) or 0x20; `busy` falls after last byte.
- `a_valid` and `b_valid` both held high, A=0x00000001, B=0x1234abcd → messages alternate A,B,A,B; each separated by one idle cycle; first message is A.
- `out_ready` toggled 1,0,0,1 pseudo-randomly during a message of 0x0f0f0f0f → every byte stable while stalled, sequence unchanged, no byte duplicated or dropped.
- `b_valid` pulsed while A message in flight and held → `b_ready` stays low until IDLE, then B accepted; `a_data` changed mid-message does not alter output.
- `reset` asserted during DIGIT state of a message → `out_valid`=0 and `busy`=0 immediately (asynchronous); after release, A and B both valid → A granted first.
- `DIGITS`=1, `b_data`=0xa → "B",":","a", terminator; total 3+T bytes.

Source files
------------

// File: rtl/hex_dump_arbiter.sv
// Two-port round-robin arbiter that serializes each accepted word as "<tag>:<hex digits><term>".
// Latency: accept at edge N, tag byte valid at N+1; one byte per cycle while out_ready is high.
// Backpressure: out_ready low holds out_byte/state; inputs are only accepted in IDLE.
// Optional: define HEX_DUMP_EOL_EN for a CR/LF terminator (default is a single space).
module hex_dump_arbiter #(
  parameter int         DIGITS = 8,
  parameter logic [7:0] TAG_A  = "A",
  parameter logic [7:0] TAG_B  = "B"
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4*DIGITS-1:0] a_data,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [4*DIGITS-1:0] b_data,
  input  logic                b_valid,
  output logic                b_ready,
  output logic [7:0]          out_byte,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(DIGITS - 1);
  localparam logic [7:0] COLON_CHR = 8'h3a;
`ifdef HEX_DUMP_EOL_EN
  localparam logic [7:0] TERM_FIRST = 8'h0d;
  localparam logic [7:0] TERM_LAST  = 8'h0a;
`else
  localparam logic [7:0] TERM_FIRST = 8'h20;
`endif

  typedef enum logic [2:0] {IDLE, TAG, COLON, DIGIT, TERM} state_t;

  state_t        state_q;
  logic [W-1:0]  shift_q;
  logic          last_q;      // 1 = port B was served last
  logic [CW-1:0] cnt_q;
  logic [7:0]    out_byte_q;
  logic          out_valid_q;
`ifdef HEX_DUMP_EOL_EN
  logic          eol_idx_q;   // 0 = CR on the wire, 1 = LF on the wire
`endif

  logic          idle;
  logic          a_grant;
  logic          b_grant;
  logic          xfer;
  logic [7:0]    digit_chr_d;
  logic [W-1:0]  shift_d;

  function automatic logic [7:0] hex_chr(input logic [3:0] n);
    hex_chr = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  // Grant only in IDLE; on a tie the port not served last wins
  always_comb begin
    idle        = (state_q == IDLE);
    a_grant     = idle && a_valid && (!b_valid || last_q);
    b_grant     = idle && b_valid && (!a_valid || !last_q);
    xfer        = out_valid_q && out_ready;
    digit_chr_d = hex_chr(shift_q[W-1 -: 4]);
    shift_d     = shift_q << 4;
  end

  // Message sequencer: latch on grant, then advance one byte per sink transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      out_byte_q  <= 8'h00;
      out_valid_q <= 1'b0;
`ifdef HEX_DUMP_EOL_EN
      eol_idx_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (a_grant || b_grant) begin
            shift_q     <= a_grant ? a_data : b_data;
            out_byte_q  <= a_grant ? TAG_A : TAG_B;
            last_q      <= b_grant;
            cnt_q       <= CNT_INIT;
            out_valid_q <= 1'b1;
            state_q     <= TAG;
          end
        end
        TAG: begin
          if (xfer) begin
            out_byte_q <= COLON_CHR;
            state_q    <= COLON;
          end
        end
        COLON: begin
          if (xfer) begin
            out_byte_q <= digit_chr_d;
            shift_q    <= shift_d;
            state_q    <= DIGIT;
          end
        end
        DIGIT: begin
          if (xfer) begin
            if (cnt_q == '0) begin
              out_byte_q <= TERM_FIRST;
              state_q    <= TERM;
            end else begin
              out_byte_q <= digit_chr_d;
              shift_q    <= shift_d;
              cnt_q      <= cnt_q - CW'(1);
            end
          end
        end
        TERM: begin
          if (xfer) begin
`ifdef HEX_DUMP_EOL_EN
            if (!eol_idx_q) begin
              out_byte_q <= TERM_LAST;
              eol_idx_q  <= 1'b1;
            end else begin
              eol_idx_q   <= 1'b0;
              out_byte_q  <= 8'h00;
              out_valid_q <= 1'b0;
              state_q     <= IDLE;
            end
`else
            out_byte_q  <= 8'h00;
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
`endif
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign a_ready   = a_grant;
  assign b_ready   = b_grant;
  assign out_byte  = out_byte_q;
  assign out_valid = out_valid_q;
  assign busy      = !idle;

endmodule
